seq_chunk_adder: RTL and testbench



---
 rtl/seq_chunk_adder_pkg.sv | 10 +
 rtl/seq_chunk_adder_chunk.sv | 20 ++
 rtl/seq_chunk_adder.sv | 88 ++++++++
 tb/tb_seq_chunk_adder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// seq_chunk_adder_pkg: FSM state encoding and size helpers for seq_chunk_adder
package seq_chunk_adder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// chunk_adder: combinational CHUNK-bit ripple adder exposing the carry into its top bit
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);
    logic [CHUNK:0] cy;
    assign cy[0] = cin;
    for (genvar i = 0; i < CHUNK; i++) begin : fa
        assign s[i]    = a[i] ^ b[i] ^ cy[i];
        assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end
    assign cout = cy[CHUNK];
    assign cmsb = cy[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle chunked add/subtract with valid/ready; SEQ_CHUNK_ADDER_OVF_EN adds ovf
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             c
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW = idx_w(NCHUNK);
    state_t state, state_d;
    logic [WIDTH-1:0] ra, rb;
    logic [IW-1:0] idx;
    logic [CHUNK-1:0] sum;
    logic cy, ov, cout, cmsb, last;
    assign last = idx == IW'(NCHUNK - 1);
    chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a   (ra[idx*CHUNK +: CHUNK]),
        .b   (rb[idx*CHUNK +: CHUNK]),
        .cin (cy),
        .s   (sum),
        .cout(cout),
        .cmsb(cmsb)
    );
    assign out_valid = ov;
    always_comb begin
        in_ready = state == IDLE;
        state_d  = state == IDLE ? (in_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                   state == DONE ? (ov && out_ready ? IDLE : DONE) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end
    // out_valid rises one cycle after entering DONE, once c/s have settled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra  <= '0;
            rb  <= '0;
            cy  <= 1'b0;
            idx <= '0;
            s   <= '0;
            c   <= 1'b0;
            ov  <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            ovf <= 1'b0;
`endif
        end else begin
            ov <= state == DONE && !(ov && out_ready);
            if (state == IDLE && in_valid) begin
                ra  <= a;
                rb  <= sub ? ~b : b;
                cy  <= sub;
                idx <= '0;
            end
            if (state == RUN) begin
                s[idx*CHUNK +: CHUNK] <= sum;
                cy  <= cout;
                idx <= last ? idx : idx + 1'b1;
                if (last) begin
                    c   <= cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                    ovf <= cmsb ^ cout;
`endif
                end
            end
        end
    end
`ifndef SEQ_CHUNK_ADDER_OVF_EN
    logic unused_cmsb;
    assign unused_cmsb = cmsb;
`endif
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: checks seq_chunk_adder at (16,4), (8,1), (12,12) against an arithmetic model
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;

    task automatic chk(input int cfg, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, nm, act, exp);
        end
    endtask

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int W = i == 0 ? 16 : i == 1 ? 8 : 12;
        localparam int C = i == 0 ? 4 : i == 1 ? 1 : 12;
        localparam int N = W / C;
        logic rst_n = 1'b1, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
        logic in_ready, out_valid, c;
        logic go = 1'b0, fin = 1'b0;
        logic [W-1:0] a = '0, b = '0, s;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        logic ovf;
`endif
        seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .s        (s),
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            .ovf      (ovf),
`endif
            .c        (c)
        );

        // Model: one operation in flight; result due N+1 edges after the accept edge
        initial begin
            logic busy;
            int k;
            logic [W:0] t;
            logic [W-1:0] bb, es;
            logic ec;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            logic eo;
            eo = 1'b0;
`endif
            busy = 1'b0;
            k = 0;
            es = '0;
            ec = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) busy = 1'b0;
                else begin
                    chk(i, "in_ready", in_ready, !busy);
                    chk(i, "out_valid", out_valid, busy && k >= N + 1);
                    if (busy && k >= N + 1) begin
                        chk(i, "s", s, es);
                        chk(i, "c", c, ec);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                        chk(i, "ovf", ovf, eo);
`endif
                    end
                    if (!busy) begin
                        if (in_valid) begin
                            busy = 1'b1;
                            k = 0;
                            bb = sub ? ~b : b;
                            t = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
                            es = t[W-1:0];
                            ec = t[W];
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                            eo = (a[W-1] == bb[W-1]) && (es[W-1] != a[W-1]);
`endif
                        end
                    end else if (k >= N + 1 && out_ready) busy = 1'b0;
                    else k++;
                end
            end
        end

        task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bv, input logic ss, input int hold,
                          output logic [W-1:0] rs, output logic rc, output int lat);
            logic acc;
            int n;
            @(posedge clk); #1;
            a = aa;
            b = bv;
            sub = ss;
            in_valid = 1'b1;
            acc = 1'b0;
            n = 0;
            while (!acc && n < 50) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                n++;
            end
            in_valid = 1'b0;
            a = ~aa;
            b = ~bv;
            sub = ~ss;
            chk(i, "accept_timeout", acc, 1);
            lat = 0;
            while (!out_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            chk(i, "result_timeout", out_valid, 1);
            rs = s;
            rc = c;
            repeat (hold) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        endtask

        if (i == 0) begin : dir
            initial begin
                logic [W-1:0] rs;
                logic rc;
                int lat;
                #2 rst_n = 1'b0;
                @(negedge clk);
                chk(i, "rst_in_ready", in_ready, 1);
                chk(i, "rst_out_valid", out_valid, 0);
                chk(i, "rst_s", s, 0);
                chk(i, "rst_c", c, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                op(16'h1234, 16'h4321, 1'b0, 0, rs, rc, lat);
                chk(i, "add_s", rs, 32'h5555);
                chk(i, "add_c", rc, 0);
                chk(i, "add_lat", lat, 5);
                op(16'hFFFF, 16'h0001, 1'b0, 0, rs, rc, lat);
                chk(i, "wrap_s", rs, 32'h0000);
                chk(i, "wrap_c", rc, 1);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                chk(i, "wrap_ovf", ovf, 0);
`endif
                op(16'h7FFF, 16'h0001, 1'b0, 0, rs, rc, lat);
                chk(i, "sovf_s", rs, 32'h8000);
                chk(i, "sovf_c", rc, 0);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                chk(i, "sovf_ovf", ovf, 1);
`endif
                op(16'h0005, 16'h0007, 1'b1, 0, rs, rc, lat);
                chk(i, "borrow_s", rs, 32'hFFFE);
                chk(i, "borrow_c", rc, 0);
                op(16'h0007, 16'h0005, 1'b1, 0, rs, rc, lat);
                chk(i, "noborrow_s", rs, 32'h0002);
                chk(i, "noborrow_c", rc, 1);
                op(16'hAAAA, 16'h5555, 1'b0, 3, rs, rc, lat);
                chk(i, "bp_s", s, 32'hFFFF);
                chk(i, "bp_c", c, 0);
                @(posedge clk); #1;
                a = 16'h1111;
                b = 16'h2222;
                sub = 1'b0;
                in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
                repeat (2) begin
                    @(posedge clk); #1;
                end
                rst_n = 1'b0;
                #1;
                chk(i, "midrst_out_valid", out_valid, 0);
                chk(i, "midrst_in_ready", in_ready, 1);
                chk(i, "midrst_s", s, 0);
                chk(i, "midrst_c", c, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                op(16'h0001, 16'h0001, 1'b0, 0, rs, rc, lat);
                chk(i, "postrst_s", rs, 32'h0002);
                chk(i, "postrst_c", rc, 0);
                chk(i, "postrst_lat", lat, 5);
                go = 1'b1;
            end
        end else begin : nodir
            initial go = 1'b1;
        end

        initial begin
            logic [W-1:0] rs;
            logic rc;
            int lat;
            wait (go);
            #2 rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            for (int n = 0; n < 1000; n++) begin
                op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3), rs, rc, lat);
                chk(i, "latency", lat, N + 1);
            end
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g[0].fin && g[1].fin && g[2].fin) && t < 90000) begin
            @(posedge clk);
            t++;
        end
        chk(9, "global_timeout", g[0].fin && g[1].fin && g[2].fin, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
